temp_sample_scheduler: RTL and testbench
========================================

TEMP_SAMPLE_SCHEDULER -- requirements
Module: temp_sample_scheduler

Interface
REQ-001 Parameter PRESC, default 10000: clk cycles per scheduler tick (1 ms at 10 MHz).
REQ-002 Parameter TIMEOUT_TICKS, default 50: max ticks allowed in WAIT before a conversion is declared failed.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 req_i  in  1  bus request; held high until ready_o.
REQ-006 we_i  in  1  1 = write, 0 = read.
REQ-007 addr_i  in  5  byte offset within block; bits [1:0] ignored.
REQ-008 wdata_i  in  32  write data.
REQ-009 rdata_o  out  32  read data, valid while ready_o = 1.
REQ-010 ready_o  out  1  one-cycle access acknowledge.
REQ-011 sens_start_o  out  1  one-cycle conversion start pulse to the I2C temperature reader.
REQ-012 sens_valid_i  in  1  one-cycle pulse: conversion complete, sens_temp_i valid.
REQ-013 sens_temp_i  in  16  signed temperature in tenths of degrees C.
REQ-014 sens_err_i  in  1  one-cycle pulse: I2C NACK/bus error.
REQ-015 irq_o  out  1  registered interrupt, level.

Function
REQ-016 Registers: 0x00 CTRL {irq_en[2], oneshot[1] (write-1, self-clearing, reads 0), auto_en[0]}; 0x04 STATUS {err[3] W1C, alarm[2] W1C, new[1] W1C, busy[0] RO}; 0x08 PERIOD[15:0] ticks; 0x0C LAST[15:0] RO; 0x10 AVG[15:0] RO; 0x14 HI[15:0]; 0x18 LO[15:0]; other offsets read 0, writes ignored.
REQ-017 Bus: ready_o asserts exactly one cycle after req_i rises, for one cycle; write takes effect on that edge; a new access needs req_i low for at least one cycle.
REQ-018 Prescaler counts 0..PRESC-1 continuously; tick = 1 clk when it wraps.
REQ-019 Period counter runs only while auto_en = 1, counts ticks; on reaching max(PERIOD,1) it raises a sample request and reloads to 0; clearing auto_en zeroes it.
REQ-020 FSM states IDLE, START, WAIT, UPDATE.
REQ-021 IDLE -> START when pending = 1; START drives sens_start_o = 1 for exactly one cycle, clears pending, -> WAIT.
REQ-022 WAIT -> UPDATE on sens_valid_i; WAIT -> IDLE setting err on sens_err_i or after TIMEOUT_TICKS ticks in WAIT; LAST/AVG unchanged on error.
REQ-023 UPDATE (one cycle): LAST <= sens_temp_i; sample pushed to 4-entry history; new <= 1; -> IDLE.
REQ-024 pending (one-deep) set by period request or oneshot write; requests while pending = 1 or in START/WAIT/UPDATE merge into one pending conversion; simultaneous period and oneshot yield one conversion.
REQ-025 busy = 1 in START, WAIT, UPDATE.
REQ-026 AVG = arithmetic shift right by 2 of the 18-bit signed sum of the 4 history entries; first sample after reset fills all 4 entries.
REQ-027 alarm set in UPDATE if signed sample > HI or < LO; equality does not alarm; set wins over same-cycle W1C.
REQ-028 sens_valid_i / sens_err_i outside WAIT are ignored.
REQ-029 irq_o <= irq_en & (alarm | err), updated every cycle.

Reset
REQ-030 On resetn = 0: FSM IDLE, CTRL = 0, STATUS = 0, PERIOD = 0x03E8, LAST = AVG = 0, history = 0, HI = 0x7FFF, LO = 0x8000, counters = 0, pending = 0, first-sample flag set; sens_start_o, ready_o, irq_o, rdata_o = 0.
REQ-031 Reset asserted mid-conversion aborts it; a sens_valid_i after release is ignored (REQ-028).

Verification
REQ-032 Write CTRL = 0x2, sensor returns 235 after 100 cycles -> exactly one sens_start_o pulse, LAST = 235, AVG = 235, STATUS = 0x2.
REQ-033 PRESC = 10, PERIOD = 3, auto_en = 1, sensor replies in 5 cycles -> sens_start_o every 30 cycles; samples 200,204,208,212 -> AVG = 206.
REQ-034 HI = 250, irq_en = 1, sample 251 -> alarm = 1, irq_o = 1 next cycle; sample 250 after W1C -> alarm stays 0.
REQ-035 Sample -55 (0xFFC9) with LO = 0 -> alarm set; AVG signed correct (0xFFC9 after first sample).
REQ-036 No sens_valid_i, PRESC = 10, TIMEOUT_TICKS = 50 -> err = 1 after 500 cycles in WAIT, LAST unchanged, FSM IDLE.
REQ-037 Oneshot written during WAIT and same-cycle period request -> exactly one further sens_start_o after current conversion completes.

Source files
------------

// File: rtl/temp_sample_scheduler_if.sv
// Register-bus handshake between a host and the temperature sample scheduler.
// One request per access; ready pulses once, read data valid only with ready.
`timescale 1ns/1ps
interface temp_sample_scheduler_if;
   logic        req_i;
   logic        we_i;
   logic [4:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        ready_o;

   modport master (output req_i, we_i, addr_i, wdata_i, input rdata_o, ready_o);
   modport slave  (input req_i, we_i, addr_i, wdata_i, output rdata_o, ready_o);
endinterface

// File: rtl/temp_sample_scheduler.sv
// Periodic / one-shot temperature conversion scheduler with LAST/AVG/alarm registers.
// Bus ack one cycle after req rises; no backpressure, merged requests collapse to one pending conversion.
`timescale 1ns/1ps
module temp_sample_scheduler #(
   parameter int PRESC         = 10000,
   parameter int TIMEOUT_TICKS = 50
) (
   input  logic                   clk,
   input  logic                   resetn,
   temp_sample_scheduler_if.slave bus,
   output logic                   sens_start_o,
   input  logic                   sens_valid_i,
   input  logic [15:0]            sens_temp_i,
   input  logic                   sens_err_i,
   output logic                   irq_o
);
   localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
   localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, UPDATE} state_t;
   state_t state;

   logic [PW-1:0]      presc_cnt;
   logic               tick;
   logic [15:0]        per_cnt;
   logic [15:0]        period;
   logic [15:0]        per_max;
   logic               per_req;
   logic [TW-1:0]      wait_cnt;
   logic               wait_expire;
   logic               req_d;
   logic               acc;
   logic               wr;
   logic               oneshot_wr;
   logic [2:0]         widx;
   logic [2:0]         w1c;
   logic               auto_en;
   logic               irq_en;
   logic               st_err;
   logic               st_alarm;
   logic               st_new;
   logic               busy;
   logic               set_err;
   logic               set_alarm;
   logic               set_new;
   logic signed [15:0] hi;
   logic signed [15:0] lo;
   logic signed [15:0] samp;
   logic signed [15:0] last;
   logic signed [15:0] avg;
   logic signed [15:0] hist [4];
   logic signed [17:0] sum;
   logic               first;
   logic               pending;
   logic [31:0]        rd_mux;
   logic               unused_bits;

   function automatic logic signed [17:0] sx(input logic signed [15:0] v);
      return {{2{v[15]}}, v};
   endfunction

   assign widx        = bus.addr_i[4:2];
   assign acc         = bus.req_i & ~req_d;
   assign wr          = acc & bus.we_i;
   assign oneshot_wr  = wr && (widx == 3'd0) && bus.wdata_i[1];
   assign w1c         = (wr && widx == 3'd1) ? bus.wdata_i[3:1] : 3'b000;
   assign unused_bits = ^{bus.addr_i[1:0], bus.wdata_i[31:16]};

   assign tick    = (presc_cnt == PRESC_LAST);
   assign per_max = (period == 16'd0) ? 16'd1 : period;
   assign per_req = auto_en & tick & ((per_cnt + 16'd1) >= per_max);
   assign busy    = (state != IDLE);

   assign wait_expire = tick && (wait_cnt == WAIT_LAST);
   assign set_err     = (state == WAIT) && !sens_valid_i && (sens_err_i || wait_expire);
   assign set_new     = (state == UPDATE);
   assign set_alarm   = (state == UPDATE) && ((samp > hi) || (samp < lo));

   // AVG is the 18-bit signed history sum shifted right arithmetically by two.
   assign sum = sx(hist[0]) + sx(hist[1]) + sx(hist[2]) + sx(hist[3]);
   assign avg = sum[17:2];

   always_comb begin
      rd_mux = '0;
      case (widx)
         3'd0:    rd_mux = {29'd0, irq_en, 1'b0, auto_en};
         3'd1:    rd_mux = {28'd0, st_err, st_alarm, st_new, busy};
         3'd2:    rd_mux = {16'd0, period};
         3'd3:    rd_mux = {16'd0, last};
         3'd4:    rd_mux = {16'd0, avg};
         3'd5:    rd_mux = {16'd0, hi};
         3'd6:    rd_mux = {16'd0, lo};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_d       <= 1'b0;
         bus.ready_o <= 1'b0;
         bus.rdata_o <= '0;
         auto_en     <= 1'b0;
         irq_en      <= 1'b0;
         period      <= 16'h03E8;
         hi          <= 16'sh7FFF;
         lo          <= 16'sh8000;
         st_err      <= 1'b0;
         st_alarm    <= 1'b0;
         st_new      <= 1'b0;
         irq_o       <= 1'b0;
      end else begin
         req_d       <= bus.req_i;
         bus.ready_o <= acc;
         bus.rdata_o <= (acc && !bus.we_i) ? rd_mux : '0;
         if (wr) begin
            case (widx)
               3'd0: begin
                  auto_en <= bus.wdata_i[0];
                  irq_en  <= bus.wdata_i[2];
               end
               3'd2:    period <= bus.wdata_i[15:0];
               3'd5:    hi     <= bus.wdata_i[15:0];
               3'd6:    lo     <= bus.wdata_i[15:0];
               default: ;
            endcase
         end
         // Hardware set has priority over a same-cycle write-1-to-clear.
         st_err   <= (st_err   & ~w1c[2]) | set_err;
         st_alarm <= (st_alarm & ~w1c[1]) | set_alarm;
         st_new   <= (st_new   & ~w1c[0]) | set_new;
         irq_o    <= irq_en & (st_alarm | st_err);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_cnt <= '0;
         per_cnt   <= '0;
      end else begin
         presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
         if (!auto_en)
            per_cnt <= '0;
         else if (tick)
            per_cnt <= per_req ? 16'd0 : per_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         sens_start_o <= 1'b0;
         wait_cnt     <= '0;
         samp         <= '0;
         last         <= '0;
         first        <= 1'b1;
         pending      <= 1'b0;
         for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else begin
         sens_start_o <= 1'b0;
         if (per_req || oneshot_wr)
            pending <= 1'b1;
         else if (state == START)
            pending <= 1'b0;
         case (state)
            IDLE: begin
               if (pending) begin
                  state        <= START;
                  sens_start_o <= 1'b1;
               end
            end
            START: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (sens_valid_i) begin
                  samp  <= sens_temp_i;
                  state <= UPDATE;
               end else if (sens_err_i || wait_expire) begin
                  state <= IDLE;
               end else if (tick) begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            UPDATE: begin
               last    <= samp;
               hist[0] <= samp;
               hist[1] <= first ? samp : hist[0];
               hist[2] <= first ? samp : hist[1];
               hist[3] <= first ? samp : hist[2];
               first   <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Scoreboard bench for temp_sample_scheduler: directed bus/sensor scenarios with hand-computed results.
// Reads and direct observations are queued by the stimulus and compared by a separate monitor.
`timescale 1ns/1ps
module tb_temp_sample_scheduler;
   localparam int PRESC         = 10;
   localparam int TIMEOUT_TICKS = 50;

   logic        clk;
   logic        resetn;
   logic        sens_start;
   logic        sens_valid;
   logic        sens_err;
   logic        irq;
   logic [15:0] sens_temp;

   temp_sample_scheduler_if bif ();

   temp_sample_scheduler #(.PRESC(PRESC), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .bus          (bif),
      .sens_start_o (sens_start),
      .sens_valid_i (sens_valid),
      .sens_temp_i  (sens_temp),
      .sens_err_i   (sens_err),
      .irq_o        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] exp_q [$];
   string       name_q [$];
   string       d_name [$];
   logic [31:0] d_act [$];
   logic [31:0] d_exp [$];
   int          checks = 0;
   int          errors = 0;
   logic        acc_rd = 1'b0;
   logic        done = 1'b0;

   int          start_cnt = 0;
   int          reply_cnt = 0;
   int          man_cnt = 0;
   int          man_done = 0;
   int          reply_delay = 5;
   logic        no_reply = 1'b0;
   int          start_cyc [64];
   logic [15:0] temp_vals [64];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      d_name.push_back(nm);
      d_act.push_back(act);
      d_exp.push_back(exp);
   endtask

   task automatic bus_acc(input logic we, input logic [4:0] a, input logic [31:0] d);
      int n;
      @(posedge clk); #1;
      bif.req_i = 1'b1; bif.we_i = we; bif.addr_i = a; bif.wdata_i = d;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bif.ready_o && n < 4);
      chk("ready_latency", n, 32'd1);
      bif.req_i = 1'b0; bif.we_i = 1'b0;
      @(posedge clk); #1;
      chk("ready_pulse", {31'd0, bif.ready_o}, 32'd0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus_acc(1'b1, a, d);
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      acc_rd = 1'b1;
      bus_acc(1'b0, a, 32'd0);
      acc_rd = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // Sensor model: answers each start pulse after reply_delay cycles unless muted.
   initial begin
      sens_valid = 1'b0;
      sens_temp  = 16'd0;
      forever begin
         @(negedge clk);
         if (resetn && sens_start) begin
            if (start_cnt < 64) start_cyc[start_cnt] = cyc;
            start_cnt++;
            if (!no_reply) begin
               repeat (reply_delay - 1) @(posedge clk);
               #1;
               sens_valid = 1'b1;
               sens_temp  = temp_vals[reply_cnt % 64];
               reply_cnt++;
               @(posedge clk); #1;
               sens_valid = 1'b0;
            end
         end else if (man_done != man_cnt) begin
            @(posedge clk); #1;
            sens_valid = 1'b1;
            sens_temp  = 16'h0063;
            @(posedge clk); #1;
            sens_valid = 1'b0;
            man_done++;
         end
      end
   end

   // Monitor: pops expected read data on each read acknowledge and drains direct observations.
   initial begin
      logic [31:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (bif.ready_o && acc_rd) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got 0x%08h with no read expected", bif.rdata_o);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (bif.rdata_o !== e) begin
                  errors++;
                  $display("FAIL %s: got 0x%08h expected 0x%08h", nm, bif.rdata_o, e);
               end
            end
         end
         while (d_exp.size() > 0) begin
            checks++;
            nm = d_name.pop_front();
            e  = d_exp.pop_front();
            if (d_act[0] !== e) begin
               errors++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", nm, d_act[0], e);
            end
            void'(d_act.pop_front());
         end
         if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL sb_leftover: got %0d unanswered reads expected 0", exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int s0;
      int k;
      int n;
      bif.req_i = 1'b0; bif.we_i = 1'b0; bif.addr_i = '0; bif.wdata_i = '0;
      sens_err = 1'b0;
      resetn   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start", {31'd0, sens_start}, 32'd0);
      chk("rst_ready", {31'd0, bif.ready_o}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_rdata", bif.rdata_o, 32'd0);
      resetn = 1'b1;

      rd(5'h00, 32'h0, "ctrl_rst");
      rd(5'h04, 32'h0, "status_rst");
      rd(5'h08, 32'h3E8, "period_rst");
      rd(5'h0C, 32'h0, "last_rst");
      rd(5'h10, 32'h0, "avg_rst");
      rd(5'h14, 32'h7FFF, "hi_rst");
      rd(5'h18, 32'h8000, "lo_rst");
      wr(5'h1C, 32'hFFFF);
      rd(5'h1C, 32'h0, "unmapped");
      rd(5'h0A, 32'h3E8, "addr_lowbits");

      // One-shot conversion, sensor answers 235 after 100 cycles.
      s0 = start_cnt;
      temp_vals[reply_cnt % 64] = 16'd235;
      reply_delay = 100;
      wr(5'h00, 32'h2);
      repeat (150) @(posedge clk);
      chk("oneshot_starts", start_cnt - s0, 32'd1);
      rd(5'h0C, 32'd235, "oneshot_last");
      rd(5'h10, 32'd235, "oneshot_avg");
      rd(5'h04, 32'h2, "oneshot_status");
      rd(5'h00, 32'h0, "oneshot_selfclear");
      wr(5'h04, 32'h2);
      rd(5'h04, 32'h0, "status_w1c");

      // Periodic sampling every 3 ticks of 10 cycles.
      do_reset();
      s0 = start_cnt;
      k  = reply_cnt;
      temp_vals[k % 64]       = 16'd200;
      temp_vals[(k + 1) % 64] = 16'd204;
      temp_vals[(k + 2) % 64] = 16'd208;
      temp_vals[(k + 3) % 64] = 16'd212;
      reply_delay = 5;
      wr(5'h08, 32'd3);
      rd(5'h08, 32'd3, "period_rw");
      wr(5'h00, 32'h1);
      n = 0;
      while (start_cnt - s0 < 4 && n < 400) begin
         @(posedge clk);
         n++;
      end
      chk("auto_starts", start_cnt - s0, 32'd4);
      repeat (12) @(posedge clk);
      wr(5'h00, 32'h0);
      repeat (60) @(posedge clk);
      chk("auto_stopped", start_cnt - s0, 32'd4);
      for (int i = 1; i < 4; i++)
         chk("period_gap", start_cyc[(s0 + i) % 64] - start_cyc[(s0 + i - 1) % 64], 32'd30);
      rd(5'h10, 32'd206, "auto_avg");
      rd(5'h0C, 32'd212, "auto_last");

      // High alarm with interrupt; equality does not alarm.
      do_reset();
      wr(5'h14, 32'd250);
      wr(5'h00, 32'h4);
      temp_vals[reply_cnt % 64] = 16'd251;
      wr(5'h00, 32'h6);
      repeat (20) @(posedge clk);
      rd(5'h04, 32'h6, "alarm_hi");
      chk("irq_alarm", {31'd0, irq}, 32'd1);
      wr(5'h04, 32'h6);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      rd(5'h04, 32'h0, "alarm_w1c");
      temp_vals[reply_cnt % 64] = 16'd250;
      wr(5'h00, 32'h6);
      repeat (20) @(posedge clk);
      rd(5'h04, 32'h2, "hi_equal");
      chk("irq_equal", {31'd0, irq}, 32'd0);
      rd(5'h10, 32'd250, "avg_mix");

      // Negative sample below LO = 0, signed averaging.
      do_reset();
      wr(5'h18, 32'd0);
      temp_vals[reply_cnt % 64] = 16'hFFC9;
      wr(5'h00, 32'h2);
      repeat (20) @(posedge clk);
      rd(5'h04, 32'h6, "alarm_lo");
      rd(5'h0C, 32'hFFC9, "neg_last");
      rd(5'h10, 32'hFFC9, "neg_avg");
      chk("irq_masked", {31'd0, irq}, 32'd0);
      temp_vals[reply_cnt % 64] = 16'd5;
      wr(5'h00, 32'h2);
      repeat (20) @(posedge clk);
      rd(5'h10, 32'hFFD8, "neg_avg2");

      // Timeout with no sensor reply, then a stray valid outside WAIT.
      do_reset();
      no_reply = 1'b1;
      wr(5'h00, 32'h2);
      repeat (440) @(posedge clk);
      rd(5'h04, 32'h1, "busy_wait");
      repeat (80) @(posedge clk);
      rd(5'h04, 32'h8, "timeout_err");
      rd(5'h0C, 32'h0, "timeout_last");
      man_cnt++;
      repeat (10) @(posedge clk);
      rd(5'h0C, 32'h0, "stray_last");
      rd(5'h04, 32'h8, "stray_status");

      // Reset in the middle of a conversion aborts it.
      do_reset();
      wr(5'h00, 32'h2);
      repeat (20) @(posedge clk);
      do_reset();
      s0 = start_cnt;
      man_cnt++;
      repeat (60) @(posedge clk);
      chk("abort_nostart", start_cnt - s0, 32'd0);
      rd(5'h04, 32'h0, "abort_status");
      rd(5'h0C, 32'h0, "abort_last");

      // Oneshot and period request on the same edge during WAIT merge into one conversion.
      do_reset();
      no_reply    = 1'b0;
      reply_delay = 45;
      k = reply_cnt;
      temp_vals[k % 64]       = 16'd10;
      temp_vals[(k + 1) % 64] = 16'd20;
      wr(5'h08, 32'd3);
      s0 = start_cnt;
      wr(5'h00, 32'h1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sens_start && n < 100);
      chk("merge_first_seen", {31'd0, sens_start}, 32'd1);
      repeat (27) @(posedge clk);
      wr(5'h00, 32'h2);
      repeat (200) @(posedge clk);
      chk("merge_starts", start_cnt - s0, 32'd2);
      rd(5'h0C, 32'd20, "merge_last");

      done = 1'b1;
   end
endmodule
